// File: rtl/alu_ops_pkg.sv
// Shared types for the ALU issue stage: operation codes, RV32I opcode constants
// and the packet carried from decode through the output/skid registers.
package alu_ops_pkg;

    localparam int ISSUE_DW = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_EQ  = 4'b1000,
        ALU_XOR = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef struct packed {
        logic [ISSUE_DW-1:0] SrcA;
        logic [ISSUE_DW-1:0] SrcB;
        alu_op_e             Operation;
        logic [4:0]          rd;
        logic                reg_write;
        logic                illegal;
    } issue_pkt_t;

    function automatic logic [ISSUE_DW-1:0] sext12(input logic [11:0] imm);
        return {{(ISSUE_DW-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode of one instruction plus its register operands
// into an ALU issue packet.
module alu_op_decode
    import alu_ops_pkg::*;
(
    input  logic [31:0]         i_instr,
    input  logic [ISSUE_DW-1:0] i_rs1_data,
    input  logic [ISSUE_DW-1:0] i_rs2_data,
    output issue_pkt_t          o_pkt
);

    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    alu_op_e             w_op;
    logic [ISSUE_DW-1:0] w_srcb;
    logic                w_reg_write;
    logic                w_bad;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Per-class operation, operand B and write-back select.
    always_comb begin
        w_op        = ALU_AND;
        w_srcb      = '0;
        w_reg_write = 1'b0;
        w_bad       = 1'b0;
        case (w_opcode)
            OPC_R: begin
                w_srcb      = i_rs2_data;
                w_reg_write = 1'b1;
                case (w_funct3)
                    3'b000: begin
                        if (w_funct7 == F7_ADD) begin
                            w_op = ALU_ADD;
                        end else if (w_funct7 == F7_SUB) begin
                            w_op = ALU_SUB;
                        end else begin
                            w_bad = 1'b1;
                        end
                    end
                    3'b111:  w_op  = ALU_AND;
                    3'b110:  w_op  = ALU_OR;
                    3'b100:  w_op  = ALU_XOR;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_I: begin
                w_srcb      = sext12(i_instr[31:20]);
                w_reg_write = 1'b1;
                case (w_funct3)
                    3'b000:  w_op  = ALU_ADD;
                    3'b111:  w_op  = ALU_AND;
                    3'b110:  w_op  = ALU_OR;
                    3'b100:  w_op  = ALU_XOR;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_op        = ALU_ADD;
                w_srcb      = sext12(i_instr[31:20]);
                w_reg_write = 1'b1;
            end
            OPC_STORE: begin
                w_op   = ALU_ADD;
                w_srcb = sext12({i_instr[31:25], i_instr[11:7]});
            end
            OPC_BRANCH: begin
                w_srcb = i_rs2_data;
                if (w_funct3 == 3'b000) begin
                    w_op = ALU_EQ;
                end else begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Unsupported encodings are still issued, but as a neutral AND 0 with no write-back.
    assign o_pkt.SrcA      = i_rs1_data;
    assign o_pkt.SrcB      = w_bad ? '0 : w_srcb;
    assign o_pkt.Operation = w_bad ? ALU_AND : w_op;
    assign o_pkt.rd        = i_instr[11:7];
    assign o_pkt.reg_write = w_bad ? 1'b0 : w_reg_write;
    assign o_pkt.illegal   = w_bad;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I instructions and issues them to the ALU through
// a two-entry (output + skid) valid/ready buffer with flush.
module alu_issue_stage
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH    = ISSUE_DW,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [4:0]               rd,
    output logic                     reg_write,
    output logic                     illegal
);

    issue_pkt_t w_dec_pkt;
    issue_pkt_t r_out_pkt;
    issue_pkt_t r_skid_pkt;
    issue_pkt_t w_out_pkt_nxt;
    issue_pkt_t w_skid_pkt_nxt;
    logic       r_out_valid;
    logic       r_skid_valid;
    logic       w_out_valid_nxt;
    logic       w_skid_valid_nxt;
    logic       w_accept;
    logic       w_drain;

    alu_op_decode u_decode (
        .i_instr    (instr),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_pkt      (w_dec_pkt)
    );

    // in_ready depends only on the skid register, never on out_ready.
    assign w_accept = in_valid & ~r_skid_valid;
    assign w_drain  = r_out_valid & out_ready;

    // Next-state of the two-entry buffer; flush wins over accept and issue.
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_pkt_nxt    = r_out_pkt;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_pkt_nxt   = r_skid_pkt;
        if (flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_out_valid || w_drain) begin
            if (r_skid_valid) begin
                w_out_pkt_nxt    = r_skid_pkt;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_out_pkt_nxt   = w_dec_pkt;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else begin
            if (w_accept) begin
                w_skid_pkt_nxt   = w_dec_pkt;
                w_skid_valid_nxt = 1'b1;
            end else begin
                w_skid_valid_nxt = r_skid_valid;
            end
        end
    end

    // Buffer state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_pkt    <= '0;
            r_skid_pkt   <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_out_pkt    <= w_out_pkt_nxt;
            r_skid_pkt   <= w_skid_pkt_nxt;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_out_valid;
    assign SrcA      = r_out_pkt.SrcA;
    assign SrcB      = r_out_pkt.SrcB;
    assign Operation = r_out_pkt.Operation;
    assign rd        = r_out_pkt.rd;
    assign reg_write = r_out_pkt.reg_write;
    assign illegal   = r_out_pkt.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with hand-computed
// expected packets, checked in order by an independent output monitor.
module tb_alu_issue_stage;
    import alu_ops_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    issue_pkt_t exp_cur;
    issue_pkt_t exp_q[$];
    issue_pkt_t prev_pkt;
    logic       prev_stall = 1'b0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .rd(rd), .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic issue_pkt_t pk(input logic [31:0] a, input logic [31:0] b,
                                      input alu_op_e op, input logic [4:0] r,
                                      input logic rw, input logic il);
        issue_pkt_t p;
        p.SrcA = a; p.SrcB = b; p.Operation = op; p.rd = r;
        p.reg_write = rw; p.illegal = il;
        return p;
    endfunction

    function automatic issue_pkt_t dut_pkt();
        issue_pkt_t p;
        p.SrcA = SrcA; p.SrcB = SrcB; p.Operation = alu_op_e'(Operation); p.rd = rd;
        p.reg_write = reg_write; p.illegal = illegal;
        return p;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor and scoreboard: pops on issue, pushes on accept, clears on flush/reset.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", {64'd0, SrcA}, 96'd0);
                end else begin
                    check("issue_pkt", {21'd0, dut_pkt()}, {21'd0, exp_q.pop_front()});
                end
            end
            if (out_valid && !out_ready && prev_stall)
                check("stall_hold", {21'd0, dut_pkt()}, {21'd0, prev_pkt});
            prev_stall = out_valid && !out_ready;
            prev_pkt   = dut_pkt();
            if (in_valid && in_ready)
                exp_q.push_back(exp_cur);
        end
    end

    // Hold one instruction on the input until it is accepted (bounded).
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input issue_pkt_t e);
        bit done = 1'b0;
        instr = ins; rs1_data = a; rs2_data = b; exp_cur = e; in_valid = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 96'd0, 96'd1);
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_done", 96'(exp_q.size()), 96'd0);
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_out_valid"}, 96'(out_valid), 96'd0);
        check({name, "_in_ready"}, 96'(in_ready), 96'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        flush = 1'b0; out_ready = 1'b0; exp_cur = '0;
        repeat (2) step();
        @(negedge clk);
        check("rst_out_valid", 96'(out_valid), 96'd0);
        check("rst_in_ready", 96'(in_ready), 96'd1);
        check("rst_pkt", {21'd0, dut_pkt()}, 96'd0);
        step();
        rst_n = 1'b1;
        step();

        // R-type ADD with one-cycle latency, then ADDI -1
        out_ready = 1'b1;
        send(32'h002081B3, 32'd5, 32'd7, pk(32'd5, 32'd7, ALU_ADD, 5'd3, 1'b1, 1'b0));
        @(negedge clk);
        check("add_latency", 96'(out_valid), 96'd1);
        step();
        send(32'hFFF00093, 32'd0, 32'd9, pk(32'd0, 32'hFFFFFFFF, ALU_ADD, 5'd1, 1'b1, 1'b0));
        wait_empty();

        // Stall: two accepted, third refused, then released in order
        out_ready = 1'b0;
        send(32'h0020C233, 32'hF0F0F0F0, 32'h0FF00FF0,
             pk(32'hF0F0F0F0, 32'h0FF00FF0, ALU_XOR, 5'd4, 1'b1, 1'b0));
        send(32'h40208133, 32'd100, 32'd30, pk(32'd100, 32'd30, ALU_SUB, 5'd2, 1'b1, 1'b0));
        instr = 32'h0F00E293; rs1_data = 32'h00000A0A; rs2_data = 32'd0; in_valid = 1'b1;
        @(negedge clk);
        check("skid_full_in_ready", 96'(in_ready), 96'd0);
        check("skid_full_out_valid", 96'(out_valid), 96'd1);
        step();
        step();
        out_ready = 1'b1;
        send(32'h0F00E293, 32'h00000A0A, 32'd0,
             pk(32'h00000A0A, 32'h000000F0, ALU_OR, 5'd5, 1'b1, 1'b0));
        wait_empty();

        // BEQ, stores with positive and negative S-immediates, load with -2048
        send(32'h00208463, 32'd11, 32'd22, pk(32'd11, 32'd22, ALU_EQ, 5'd8, 1'b0, 1'b0));
        send(32'h0020A423, 32'h1000, 32'd3, pk(32'h1000, 32'd8, ALU_ADD, 5'd8, 1'b0, 1'b0));
        send(32'hFE20AE23, 32'h1000, 32'd3,
             pk(32'h1000, 32'hFFFFFFFC, ALU_ADD, 5'd28, 1'b0, 1'b0));
        send(32'h8000A303, 32'h2000, 32'd0,
             pk(32'h2000, 32'hFFFFF800, ALU_ADD, 5'd6, 1'b1, 1'b0));
        wait_empty();

        // Flush with both entries full and a pending input
        out_ready = 1'b0;
        send(32'h002081B3, 32'd1, 32'd2, pk(32'd1, 32'd2, ALU_ADD, 5'd3, 1'b1, 1'b0));
        send(32'h40208133, 32'd1, 32'd2, pk(32'd1, 32'd2, ALU_SUB, 5'd2, 1'b1, 1'b0));
        instr = 32'h0020C233; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_full");
        out_ready = 1'b1;
        repeat (3) step();

        // Flush drops an instruction accepted in the same cycle
        out_ready = 1'b0;
        send(32'h002081B3, 32'd1, 32'd2, pk(32'd1, 32'd2, ALU_ADD, 5'd3, 1'b1, 1'b0));
        instr = 32'h40208133; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_accept");
        out_ready = 1'b1;
        repeat (3) step();

        // Reset while stalled, then illegal encodings
        out_ready = 1'b0;
        send(32'h002081B3, 32'd1, 32'd2, pk(32'd1, 32'd2, ALU_ADD, 5'd3, 1'b1, 1'b0));
        send(32'h0020C233, 32'd1, 32'd2, pk(32'd1, 32'd2, ALU_XOR, 5'd4, 1'b1, 1'b0));
        rst_n = 1'b0; in_valid = 1'b1;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rst_stall_pkt", {21'd0, dut_pkt()}, 96'd0);
        step();
        check_idle("rst_stall");
        out_ready = 1'b1;
        send(32'h0000007F, 32'h1234, 32'h5678, pk(32'h1234, 32'd0, ALU_AND, 5'd0, 1'b0, 1'b1));
        send(32'h02208133, 32'd3, 32'd4, pk(32'd3, 32'd0, ALU_AND, 5'd2, 1'b0, 1'b1));
        send(32'h00209463, 32'd3, 32'd4, pk(32'd3, 32'd0, ALU_AND, 5'd8, 1'b0, 1'b1));
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
